// File: rtl/axis_pixel_bram_writer_pkg.sv
// axis_pixel_pkg: shared lane geometry, direction indices and FSM states for the pixel BRAM writer
package axis_pixel_pkg;
  localparam int LANE_W = 16;
  localparam int NUM_LANES = 9;
  localparam int BEAT_W = NUM_LANES * LANE_W;
  localparam int LANE_C0 = 0;
  localparam int LANE_N = 1;
  localparam int LANE_NE = 2;
  localparam int LANE_E = 3;
  localparam int LANE_SE = 4;
  localparam int LANE_S = 5;
  localparam int LANE_SW = 6;
  localparam int LANE_W_DIR = 7;
  localparam int LANE_NW = 8;
  typedef enum logic [1:0] {IDLE, RECV, DRAIN, DONE} state_e;
endpackage

// File: rtl/axis_pixel_bram_writer_if.sv
// axis_pixel_bram_writer_if: AXI-Stream beat bus carrying nine packed lattice lanes
interface axis_pixel_bram_writer_if;
  import axis_pixel_pkg::*;
  logic tvalid;
  logic tready;
  logic [BEAT_W-1:0] tdata;
  logic [BEAT_W/8-1:0] tstrb;
  logic tlast;
  modport master (output tvalid, tdata, tstrb, tlast, input tready);
  modport slave (input tvalid, tdata, tstrb, tlast, output tready);
endinterface

// File: rtl/axis_pixel_bram_writer.sv
// axis_pixel_bram_writer: AXIS slave writing each beat's nine lanes to direction BRAMs at sequential addresses
module axis_pixel_bram_writer
  import axis_pixel_pkg::*;
#(
  parameter int DATA_WIDTH = LANE_W,
  parameter int DEPTH = 2500,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic s00_axis_aclk,
  input  logic s00_axis_areset,
  input  logic frame_arm,
  axis_pixel_bram_writer_if.slave s00_axis,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [NUM_LANES-1:0] wr_en,
  output logic [BEAT_W-1:0] wr_data,
  output logic busy,
  output logic frame_done,
  output logic frame_err,
  output logic [ADDRESS_WIDTH:0] beat_count
);
  localparam int SB = DATA_WIDTH / 8;
  localparam logic [ADDRESS_WIDTH:0] LAST = (ADDRESS_WIDTH + 1)'(DEPTH - 1);
  state_e state_q;
  logic tready_q, done_q, err_q;
  logic [NUM_LANES-1:0] wr_en_q, lane_full, lane_part;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [BEAT_W-1:0] wr_data_q;
  logic [ADDRESS_WIDTH:0] count_q;
  logic hs;
  // a lane is written only with both byte strobes; a half strobe is a framing error
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    assign lane_full[k] = &s00_axis.tstrb[k*SB +: SB];
    assign lane_part[k] = |s00_axis.tstrb[k*SB +: SB] && !lane_full[k];
  end
  assign hs = s00_axis.tvalid && tready_q;
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state_q <= IDLE;
      tready_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      wr_en_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      count_q <= '0;
    end else begin
      wr_en_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_arm) begin
          state_q <= RECV;
          tready_q <= 1'b1;
          count_q <= '0;
          err_q <= 1'b0;
        end
        RECV: if (hs) begin
          wr_addr_q <= count_q[ADDRESS_WIDTH-1:0];
          wr_data_q <= s00_axis.tdata;
          wr_en_q <= lane_full;
          count_q <= count_q + 1'b1;
          if (|lane_part || (s00_axis.tlast != (count_q == LAST))) err_q <= 1'b1;
          if (s00_axis.tlast) begin
            state_q <= DONE;
            tready_q <= 1'b0;
            done_q <= 1'b1;
          end else if (count_q == LAST) state_q <= DRAIN;
        end
        // count already sits at DEPTH here; surplus beats are swallowed until tlast
        DRAIN: if (hs && s00_axis.tlast) begin
          state_q <= DONE;
          tready_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign s00_axis.tready = tready_q;
  assign wr_addr = wr_addr_q;
  assign wr_en = wr_en_q;
  assign wr_data = wr_data_q;
  assign busy = state_q == RECV || state_q == DRAIN;
  assign frame_done = done_q;
  assign frame_err = err_q;
  assign beat_count = count_q;
endmodule

// File: tb/tb_axis_pixel_bram_writer.sv
// tb_axis_pixel_bram_writer: directed frames with a write scoreboard for axis_pixel_bram_writer
module tb_axis_pixel_bram_writer;
  import axis_pixel_pkg::*;
  localparam int DEPTH = 2500;
  localparam int AW = 12;
  typedef struct {
    int due;
    logic [AW-1:0] addr;
    logic [8:0] en;
    logic [143:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_arm = 1'b0;
  logic [AW-1:0] wr_addr;
  logic [8:0] wr_en;
  logic [143:0] wr_data;
  logic busy, frame_done, frame_err;
  logic [AW:0] beat_count;
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  exp_t q[$];
  axis_pixel_bram_writer_if s_if ();
  axis_pixel_bram_writer #(.DATA_WIDTH(16), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
    .s00_axis_aclk(clk),
    .s00_axis_areset(rst),
    .frame_arm(frame_arm),
    .s00_axis(s_if),
    .wr_addr(wr_addr),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .busy(busy),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .beat_count(beat_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [143:0] mk(input int bi);
    logic [143:0] d;
    for (int k = 0; k < 9; k++) d[16*k +: 16] = {4'(k), 12'(bi)};
    return d;
  endfunction
  // every write must land exactly on the cycle its handshake scheduled; otherwise wr_en stays low
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (q.size() != 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("write", {cyc, wr_en, wr_addr, wr_data}, {e.due, e.en, e.addr, e.data});
    end else chk("idle_wr_en", wr_en, 9'h0);
  end
  task automatic send_beat(input int bi, input bit last, input logic [17:0] strb, input logic [8:0] en);
    bit got;
    exp_t e;
    got = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata = mk(bi);
    s_if.tstrb = strb;
    s_if.tlast = last;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (s_if.tready) begin
        got = 1'b1;
        if (bi < DEPTH && en != 9'h0) begin
          e.due = cyc + 1;
          e.addr = 12'(bi);
          e.en = en;
          e.data = mk(bi);
          q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    chk("handshake", got, 1);
  endtask
  task automatic arm();
    frame_arm = 1'b1;
    @(posedge clk);
    #1;
    frame_arm = 1'b0;
  endtask
  task automatic send_frame(input int n, input int last_at, input int duty, input int arm_at, input bit strb_test);
    for (int bi = 0; bi < n; bi++) begin
      while ($urandom_range(99) >= duty) begin
        @(posedge clk);
        #1;
      end
      frame_arm = (bi == arm_at);
      if (strb_test && bi == 5) send_beat(bi, bi == last_at, 18'h3FFFC, 9'h1FE);
      else if (strb_test && bi == 6) send_beat(bi, bi == last_at, 18'h3FFFB, 9'h1FD);
      else send_beat(bi, bi == last_at, 18'h3FFFF, 9'h1FF);
      frame_arm = 1'b0;
    end
  endtask
  task automatic end_frame(input bit exp_err, input int exp_cnt, input bit arm_in_done);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        if (arm_in_done) begin
          frame_arm = 1'b1;
          @(posedge clk);
          #1;
          frame_arm = 1'b0;
        end
      end
    end
    chk("done_seen", seen, 1);
    repeat (4) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    chk("frame_err", frame_err, exp_err);
    chk("beat_count", beat_count, exp_cnt);
    chk("tready_after", s_if.tready, 0);
    chk("busy_after", busy, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tstrb = '0;
    s_if.tlast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {s_if.tready, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, beat_count}, '0);
    @(posedge clk);
    #1;
    arm();
    send_frame(DEPTH, DEPTH - 1, 100, -1, 0);
    end_frame(0, DEPTH, 0);
    arm();
    send_frame(DEPTH, DEPTH - 1, 30, 50, 0);
    end_frame(0, DEPTH, 0);
    arm();
    send_frame(100, 99, 100, -1, 0);
    end_frame(1, 100, 1);
    arm();
    send_frame(DEPTH + 10, DEPTH + 9, 100, -1, 0);
    end_frame(1, DEPTH, 0);
    arm();
    send_frame(DEPTH, DEPTH - 1, 100, -1, 1);
    end_frame(1, DEPTH, 0);
    arm();
    send_frame(1000, -1, 100, -1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset", {s_if.tready, wr_en, wr_addr, wr_data, busy, frame_done, frame_err, beat_count}, '0);
    @(posedge clk);
    #1;
    arm();
    send_frame(DEPTH, DEPTH - 1, 100, -1, 0);
    end_frame(0, DEPTH, 0);
    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
